// File: rtl/cpu_player_if.sv
// cpu_player_if
//   Groups the game-facing signals of the automated opponent.
//   master : the game/top level. Drives enable and difficulty, observes the press outputs.
//   slave  : cpu_player itself.
//   Signals:
//     enable       1 = game running, 0 = suppress new presses
//     difficulty   press threshold, compared unsigned against the LFSR
//     press        synthetic button, active-high, registered
//     press_count  presses issued since reset, saturates at 255
//     lfsr_q       current LFSR state (debug visibility)
interface cpu_player_if;
  logic       enable;
  logic [9:0] difficulty;
  logic       press;
  logic [7:0] press_count;
  logic [9:0] lfsr_q;

  modport master (
    output enable,
    output difficulty,
    input  press,
    input  press_count,
    input  lfsr_q
  );

  modport slave (
    input  enable,
    input  difficulty,
    output press,
    output press_count,
    output lfsr_q
  );
endinterface

// File: rtl/cpu_player.sv
// cpu_player
//   Automated tug-of-war opponent. Once per decision tick it compares a 10-bit XNOR LFSR
//   against the difficulty threshold. On a hit it emits a press pulse HOLD_CYC cycles wide,
//   then stays quiet until the following tick, so the downstream edge detector always sees
//   a distinct low period between presses.
//   Ports:
//     clk    system clock (CLOCK_50)
//     reset  asynchronous, active-high
//     bus    cpu_player_if.slave: enable, difficulty in; press, press_count, lfsr_q out
//   Parameters:
//     TICK_DIV  clk cycles per decision tick (>= 2)
//     HOLD_CYC  clk cycles press stays high (>= 1)
//     LFSR_W    LFSR width; the feedback taps only make sense for 10
module cpu_player #(
  parameter int TICK_DIV = 1_000_000,
  parameter int HOLD_CYC = 4,
  parameter int LFSR_W   = 10
) (
  input  logic        clk,
  input  logic        reset,
  cpu_player_if.slave bus
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  tick_cnt_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] lfsr_next;
  logic [7:0]        count_reg;
  logic              press_reg;
  logic              tick;
  logic              hit;

  assign tick = (tick_cnt_reg == TICK_LAST);

  // XNOR feedback: all-zeros is a legal state, all-ones is the lock-up state and is
  // never reached from the reset value.
  assign lfsr_next = {lfsr_reg[8:0], ~(lfsr_reg[9] ^ lfsr_reg[6])};

  // Decision uses the LFSR value before this tick's shift.
  assign hit = tick & bus.enable & (bus.difficulty > lfsr_reg);

  // Free-running decision tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  // LFSR advances on every tick, independent of enable and FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_reg <= '0;
    end else if (tick) begin
      lfsr_reg <= lfsr_next;
    end
  end

  // Press FSM. press_reg is loaded with the decode of the next state so the output
  // is registered and aligned with state_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      count_reg <= '0;
      press_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit) begin
            state_reg <= PRESS;
            press_reg <= 1'b1;
            hold_reg  <= HOLD_LOAD;
            if (count_reg != 8'hFF) begin
              count_reg <= count_reg + 8'd1;
            end
          end
        end
        PRESS: begin
          // Ticks landing here are not decisions; losing enable cuts the pulse short.
          if (!bus.enable || (hold_reg == '0)) begin
            state_reg <= RELEASE;
            press_reg <= 1'b0;
          end else begin
            hold_reg <= hold_reg - 1'b1;
          end
        end
        RELEASE: begin
          // The tick that ends RELEASE is consumed here; any hit on it is dropped.
          if (tick) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          press_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press       = press_reg;
  assign bus.press_count = count_reg;
  assign bus.lfsr_q      = lfsr_reg;

endmodule

// File: tb/tb_cpu_player.sv
// tb_cpu_player
//   Drives cpu_player with TICK_DIV=4, HOLD_CYC=2. A behavioural model (edge counter,
//   press-remaining counter, wait-for-tick flag) predicts press, press_count and lfsr_q
//   every cycle; directed steps add literal expectations for the documented scenarios,
//   followed by a randomized phase.
module tb_cpu_player;
  localparam int TD = 4;
  localparam int HC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  cpu_player_if bus ();

  cpu_player #(.TICK_DIV(TD), .HOLD_CYC(HC), .LFSR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_edge;   // rising edges since reset release
  int         m_left;   // remaining press-high cycles
  bit         m_wait;   // press issued, waiting for a tick after it ends
  int         m_count;
  logic [9:0] m_lfsr;

  always @(posedge clk or posedge reset) begin
    bit t;
    if (reset) begin
      m_edge = 0; m_left = 0; m_wait = 0; m_count = 0; m_lfsr = '0;
    end else begin
      m_edge++;
      t = (m_edge % TD) == 0;
      if (m_left > 0) begin
        if (!bus.enable) m_left = 0;
        else m_left--;
      end else if (m_wait) begin
        if (t) m_wait = 0;
      end else if (t && bus.enable && (bus.difficulty > m_lfsr)) begin
        m_left = HC;
        m_wait = 1;
        if (m_count < 255) m_count++;
      end
      if (t) m_lfsr = {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])};
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_press", {31'd0, bus.press}, {31'd0, (m_left > 0)});
      check("model_count", {24'd0, bus.press_count}, m_count);
      check("model_lfsr",  {22'd0, bus.lfsr_q}, {22'd0, m_lfsr});
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge where reset is released.
  task automatic restart(input logic en, input logic [9:0] d);
    reset = 1'b1;
    bus.enable = en;
    bus.difficulty = d;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_t2_schedule(input string tag);
    for (int e = 1; e <= 24; e++) begin
      @(negedge clk);
      check(tag, {31'd0, bus.press},
            {31'd0, (e == 4 || e == 5 || e == 12 || e == 13 || e == 20 || e == 21)});
      if (e == 21) check({tag, "_count"}, {24'd0, bus.press_count}, 32'd3);
    end
  endtask

  initial begin
    logic [9:0] t1_exp [4];
    int seen;
    int rises;
    logic prev;
    t1_exp[0] = 10'h001; t1_exp[1] = 10'h003; t1_exp[2] = 10'h007; t1_exp[3] = 10'h00F;
    bus.enable = 1'b0;
    bus.difficulty = '0;
    repeat (2) @(negedge clk);
    check("reset_press", {31'd0, bus.press}, 32'd0);
    check("reset_count", {24'd0, bus.press_count}, 32'd0);
    check("reset_lfsr",  {22'd0, bus.lfsr_q}, 32'd0);

    // 1: difficulty 0 never presses; LFSR start sequence
    restart(1'b1, 10'd0);
    seen = 0;
    for (int e = 1; e <= 5000; e++) begin
      @(negedge clk);
      if (bus.press) seen++;
      if (e % 4 == 0 && e <= 16) check("t1_lfsr", {22'd0, bus.lfsr_q}, {22'd0, t1_exp[e/4-1]});
    end
    check("t1_press_never", seen, 32'd0);
    check("t1_count", {24'd0, bus.press_count}, 32'd0);
    $display("step 1: difficulty=0, 5000 cycles, press highs=%0d", seen);

    // 2: difficulty 1023 -> 8-cycle period, 2 cycles high
    restart(1'b1, 10'd1023);
    check_t2_schedule("t2_press");
    $display("step 2: difficulty=1023, count=%0d", bus.press_count);

    // 3: difficulty 1 -> only when lfsr_q == 0
    restart(1'b1, 10'd1);
    for (int e = 1; e <= 4000; e++) begin
      @(negedge clk);
      if (e == 4) check("t3_first_press", {31'd0, bus.press}, 32'd1);
      if (e == 8) check("t3_tick2_absorbed", {31'd0, bus.press}, 32'd0);
    end
    check("t3_count", {24'd0, bus.press_count}, 32'd1);
    $display("step 3: difficulty=1, count after 1000 ticks=%0d", bus.press_count);

    // 4: drop enable as press rises
    restart(1'b1, 10'd1023);
    repeat (4) @(negedge clk);
    check("t4_press_rise", {31'd0, bus.press}, 32'd1);
    bus.enable = 1'b0;
    for (int e = 5; e <= 60; e++) begin
      @(negedge clk);
      if (e == 5) check("t4_press_cut", {31'd0, bus.press}, 32'd0);
      if (e == 32) check("t4_lfsr_8ticks", {22'd0, bus.lfsr_q}, 32'h0FE);
    end
    check("t4_count", {24'd0, bus.press_count}, 32'd1);
    $display("step 4: enable dropped, lfsr=0x%0h", bus.lfsr_q);

    // 5: async reset mid-press, then identical timing to step 2
    restart(1'b1, 10'd1023);
    repeat (4) @(negedge clk);
    check("t5_press_high", {31'd0, bus.press}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_press", {31'd0, bus.press}, 32'd0);
    check("t5_async_count", {24'd0, bus.press_count}, 32'd0);
    check("t5_async_lfsr",  {22'd0, bus.lfsr_q}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_t2_schedule("t5_press");
    $display("step 5: async reset mid-press, restart schedule checked");

    // 6: saturation
    restart(1'b1, 10'd1023);
    rises = 0;
    prev = 1'b0;
    for (int e = 1; e <= 2400; e++) begin
      @(negedge clk);
      if (bus.press && !prev) rises++;
      prev = bus.press;
    end
    check("t6_rises", rises, 32'd300);
    check("t6_count_sat", {24'd0, bus.press_count}, 32'd255);
    $display("step 6: %0d presses, count=%0d", rises, bus.press_count);

    // 7: randomized enable/difficulty/reset
    restart(1'b1, 10'($urandom_range(0, 1023)));
    for (int c = 0; c < 8000; c++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        case ($urandom_range(0, 3))
          0: bus.difficulty = 10'd0;
          1: bus.difficulty = 10'd1023;
          default: bus.difficulty = 10'($urandom_range(0, 1023));
        endcase
      end else if (r < 6) begin
        bus.enable = ~bus.enable;
      end else if (r == 6 && $urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    $display("step 7: random phase done, count=%0d", bus.press_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
